// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One product/quotient bit per cycle, sign fix-up in a final cycle.
module alu_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] reg_lo,
  output logic [DATA_W-1:0] reg_hi
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]    cnt_reg;
  logic [2*DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0]   rem_reg;
  logic [DATA_W-1:0]   b_reg;
  logic [DATA_W-1:0]   d1_reg;
  logic                is_div_reg;
  logic                neg_q_reg;
  logic                neg_r_reg;
  logic                dz_reg;
  logic                done_reg;
  logic                div_zero_reg;
  logic [DATA_W-1:0]   lo_reg;
  logic [DATA_W-1:0]   hi_reg;

  logic                accept;
  logic                signed_op;
  logic [DATA_W-1:0]   abs1;
  logic [DATA_W-1:0]   abs2;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic                div_ge;
  logic [DATA_W-1:0]   rem_next;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;

  assign accept    = (state_reg == IDLE) && start && !cancel;
  assign signed_op = op[0];
  assign abs1 = (signed_op && data1[DATA_W-1]) ? -data1 : data1;
  assign abs2 = (signed_op && data2[DATA_W-1]) ? -data2 : data2;

  // Shift-add: the multiplier sits in the low half and drains out bit by bit.
  assign mul_sum  = {1'b0, acc_reg[2*DATA_W-1:DATA_W]} + (acc_reg[0] ? {1'b0, b_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[DATA_W-1:1]};

  // Restoring step on a DATA_W+1-bit partial remainder; MSB of the difference is the borrow.
  assign div_shift = {rem_reg, acc_reg[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, b_reg};
  assign div_ge    = ~div_diff[DATA_W];
  assign rem_next  = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];

  assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;
  assign quot_fix = neg_q_reg ? -acc_reg[DATA_W-1:0] : acc_reg[DATA_W-1:0];
  assign rem_fix  = neg_r_reg ? -rem_reg : rem_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept && !op[2]) state_next = RUN;
      RUN: begin
        if (cancel)                       state_next = IDLE;
        else if (cnt_reg == CNT_W'(1))    state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg      <= '0;
      acc_reg      <= '0;
      rem_reg      <= '0;
      b_reg        <= '0;
      d1_reg       <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      dz_reg       <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      lo_reg       <= '0;
      hi_reg       <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (!op[2]) begin
              cnt_reg    <= CNT_W'(DATA_W);
              rem_reg    <= '0;
              d1_reg     <= data1;
              is_div_reg <= op[1];
              neg_q_reg  <= signed_op & (data1[DATA_W-1] ^ data2[DATA_W-1]);
              neg_r_reg  <= signed_op & data1[DATA_W-1];
              dz_reg     <= (data2 == '0);
              acc_reg    <= {{DATA_W{1'b0}}, (op[1] ? abs1 : abs2)};
              b_reg      <= op[1] ? abs2 : abs1;
            end else if (op == 3'd4) begin
              lo_reg <= data1;
            end else if (op == 3'd5) begin
              hi_reg <= data1;
            end
          end
        end
        RUN: begin
          if (!cancel) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (is_div_reg) begin
              acc_reg[DATA_W-1:0] <= {acc_reg[DATA_W-2:0], div_ge};
              rem_reg             <= rem_next;
            end else begin
              acc_reg <= mul_next;
            end
          end
        end
        FIX: begin
          if (!cancel) begin
            done_reg     <= 1'b1;
            div_zero_reg <= is_div_reg & dz_reg;
            if (!is_div_reg) begin
              hi_reg <= prod_fix[2*DATA_W-1:DATA_W];
              lo_reg <= prod_fix[DATA_W-1:0];
            end else if (dz_reg) begin
              // Divide by zero bypasses sign fix-up: all-ones quotient, raw dividend.
              lo_reg <= '1;
              hi_reg <= d1_reg;
            end else begin
              lo_reg <= quot_fix;
              hi_reg <= rem_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign done     = done_reg;
  assign div_zero = div_zero_reg;
  assign reg_lo   = lo_reg;
  assign reg_hi   = hi_reg;

endmodule
